// File: rtl/alu16_pkg.sv
// rtl/alu16_pkg.sv - shared opcodes, flag positions and queue states for the ALU execute stage
package alu16_pkg;

  localparam int WIDTH = 16;

  localparam logic [2:0] OP_AND  = 3'b000;
  localparam logic [2:0] OP_OR   = 3'b001;
  localparam logic [2:0] OP_XOR  = 3'b010;
  localparam logic [2:0] OP_NOT  = 3'b011;
  localparam logic [2:0] OP_ADD  = 3'b100;
  localparam logic [2:0] OP_SUB  = 3'b101;
  localparam logic [2:0] OP_INC  = 3'b110;
  localparam logic [2:0] OP_PASS = 3'b111;

  localparam int FLAG_Z = 3;
  localparam int FLAG_N = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  // Occupancy of the 2-entry result queue.
  typedef enum logic [1:0] {
    Q_EMPTY = 2'd0,
    Q_ONE   = 2'd1,
    Q_FULL  = 2'd2
  } q_state_e;

endpackage

// File: rtl/alu16_exec_stage_if.sv
// rtl/alu16_exec_stage_if.sv - operation input and result output handshake bundle
interface alu16_exec_stage_if;
  import alu16_pkg::*;

  logic             in_valid;
  logic             in_ready;
  logic [2:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic [3:0]       flags;

  modport master (
    output in_valid, op, a, b, out_ready,
    input  in_ready, out_valid, result, flags
  );

  modport slave (
    input  in_valid, op, a, b, out_ready,
    output in_ready, out_valid, result, flags
  );

endinterface

// File: rtl/not16.sv
// rtl/not16.sv - 16-bit structural inverter
module not16 (
  input  logic [15:0] a_i,
  output logic [15:0] y_o
);

  // One inverter per bit.
  for (genvar i = 0; i < 16; i++) begin : g_inv
    not u_not (y_o[i], a_i[i]);
  end

endmodule

// File: rtl/alu16_exec_stage.sv
// rtl/alu16_exec_stage.sv - registered 16-bit ALU execute stage with 2-entry result queue
module alu16_exec_stage
  import alu16_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  alu16_exec_stage_if.slave  bus
);

  localparam int MSB = WIDTH - 1;

  logic [WIDTH-1:0] inv_in;
  logic [WIDTH-1:0] inv_out;
  logic [WIDTH-1:0] addend;
  logic             cin;
  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] alu_r;
  logic [3:0]       alu_f;

  q_state_e         state_q, state_d;
  logic             wr_ptr_q, wr_ptr_d;
  logic             rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0] ent_res_q [DEPTH];
  logic [WIDTH-1:0] ent_res_d [DEPTH];
  logic [3:0]       ent_flg_q [DEPTH];
  logic [3:0]       ent_flg_d [DEPTH];
  logic [WIDTH-1:0] result_q, result_d;
  logic [3:0]       flags_q, flags_d;

  logic             in_ready_w;
  logic             out_valid_w;
  logic             push;
  logic             pop;

  // The shared inverter sees A for NOT and B for SUB.
  always_comb begin
    inv_in = (bus.op == OP_NOT) ? bus.a : bus.b;
  end

  not16 u_not16 (
    .a_i (inv_in),
    .y_o (inv_out)
  );

  // Second adder operand and carry-in for ADD/SUB/INC.
  always_comb begin
    addend = '0;
    cin    = 1'b0;
    case (bus.op)
      OP_ADD:  addend = bus.b;
      OP_SUB:  begin addend = inv_out; cin = 1'b1; end
      OP_INC:  cin = 1'b1;
      default: ;
    endcase
  end

  assign sum = {1'b0, bus.a} + {1'b0, addend} + {{WIDTH{1'b0}}, cin};

  // Result and flags; logic ops and PASS leave C and V clear.
  always_comb begin
    alu_r = '0;
    alu_f = '0;
    case (bus.op)
      OP_AND:  alu_r = bus.a & bus.b;
      OP_OR:   alu_r = bus.a | bus.b;
      OP_XOR:  alu_r = bus.a ^ bus.b;
      OP_NOT:  alu_r = inv_out;
      OP_PASS: alu_r = bus.b;
      default: begin
        alu_r         = sum[WIDTH-1:0];
        alu_f[FLAG_C] = sum[WIDTH];
        alu_f[FLAG_V] = (bus.a[MSB] == addend[MSB]) && (alu_r[MSB] != bus.a[MSB]);
      end
    endcase
    alu_f[FLAG_Z] = (alu_r == '0);
    alu_f[FLAG_N] = alu_r[MSB];
  end

  assign in_ready_w  = (state_q != Q_FULL);
  assign out_valid_w = (state_q != Q_EMPTY);
  assign push        = bus.in_valid & in_ready_w;
  assign pop         = out_valid_w & bus.out_ready;

  // Queue occupancy transitions.
  always_comb begin
    state_d = state_q;
    case (state_q)
      Q_EMPTY: if (push) state_d = Q_ONE;
      Q_ONE: begin
        if (push && !pop)      state_d = Q_FULL;
        else if (pop && !push) state_d = Q_EMPTY;
      end
      Q_FULL:  if (pop) state_d = Q_ONE;
      default: state_d = Q_EMPTY;
    endcase
  end

  // Entry writes, pointer advance and the registered head view; the head
  // view holds its last value once the queue drains.
  always_comb begin
    ent_res_d = ent_res_q;
    ent_flg_d = ent_flg_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    result_d  = result_q;
    flags_d   = flags_q;
    if (push) begin
      ent_res_d[wr_ptr_q] = alu_r;
      ent_flg_d[wr_ptr_q] = alu_f;
      wr_ptr_d            = ~wr_ptr_q;
    end
    if (pop) begin
      rd_ptr_d = ~rd_ptr_q;
    end
    if (state_d != Q_EMPTY) begin
      result_d = ent_res_d[rd_ptr_d];
      flags_d  = ent_flg_d[rd_ptr_d];
    end
  end

  // State registers; reset discards everything queued or in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= Q_EMPTY;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      result_q <= '0;
      flags_q  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        ent_res_q[i] <= '0;
        ent_flg_q[i] <= '0;
      end
    end else begin
      state_q   <= state_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      result_q  <= result_d;
      flags_q   <= flags_d;
      ent_res_q <= ent_res_d;
      ent_flg_q <= ent_flg_d;
    end
  end

  assign bus.in_ready  = in_ready_w;
  assign bus.out_valid = out_valid_w;
  assign bus.result    = result_q;
  assign bus.flags     = flags_q;

endmodule

// File: tb/tb_alu16_exec_stage.sv
// tb/tb_alu16_exec_stage.sv - directed self-checking bench for the ALU execute stage
module tb_alu16_exec_stage;
  import alu16_pkg::*;

  logic clk;
  logic rst_n;
  int   n_vec;
  int   n_err;

  alu16_exec_stage_if bus_if ();

  alu16_exec_stage dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [2:0] o, input logic [15:0] a, input logic [15:0] b);
    bus_if.in_valid = v;
    bus_if.op       = o;
    bus_if.a        = a;
    bus_if.b        = b;
  endtask

  // Apply one op with out_ready=1 and check the head right after the accepting edge.
  task automatic one_op(input string tag, input logic [2:0] o, input logic [15:0] a,
                        input logic [15:0] b, input logic [15:0] er, input logic [3:0] ef);
    drive(1'b1, o, a, b);
    tick();
    drive(1'b0, o, a, b);
    chk({tag, ".valid"}, {31'd0, bus_if.out_valid}, 32'd1);
    chk({tag, ".result"}, {16'd0, bus_if.result}, {16'd0, er});
    chk({tag, ".flags"}, {28'd0, bus_if.flags}, {28'd0, ef});
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    rst_n = 1'b0;
    bus_if.out_ready = 1'b1;
    drive(1'b0, OP_AND, 16'h0000, 16'h0000);

    repeat (3) tick();
    chk("rst.out_valid", {31'd0, bus_if.out_valid}, 32'd0);
    chk("rst.result", {16'd0, bus_if.result}, 32'h0);
    chk("rst.flags", {28'd0, bus_if.flags}, 32'h0);
    chk("rst.in_ready", {31'd0, bus_if.in_ready}, 32'd1);
    rst_n = 1'b1;
    tick();

    // Flags are {Z,N,C,V}.
    one_op("add_ovf",  OP_ADD,  16'h7FFF, 16'h0001, 16'h8000, 4'b0101);
    one_op("sub_eq",   OP_SUB,  16'h0005, 16'h0005, 16'h0000, 4'b1010);
    one_op("sub_brw",  OP_SUB,  16'h0003, 16'h0005, 16'hFFFE, 4'b0100);
    one_op("not",      OP_NOT,  16'h00FF, 16'h1234, 16'hFF00, 4'b0100);
    one_op("xor",      OP_XOR,  16'hAAAA, 16'hAAAA, 16'h0000, 4'b1000);
    one_op("inc_wrap", OP_INC,  16'hFFFF, 16'h5555, 16'h0000, 4'b1010);
    one_op("and",      OP_AND,  16'hF0F0, 16'hFF00, 16'hF000, 4'b0100);
    one_op("or",       OP_OR,   16'h0F00, 16'h00F0, 16'h0FF0, 4'b0000);
    one_op("add_cz",   OP_ADD,  16'h8000, 16'h8000, 16'h0000, 4'b1011);
    one_op("sub_v",    OP_SUB,  16'h8000, 16'h0001, 16'h7FFF, 4'b0011);

    // Drained queue keeps the last result visible.
    tick();
    chk("drain.out_valid", {31'd0, bus_if.out_valid}, 32'd0);
    chk("drain.hold", {16'd0, bus_if.result}, 32'h7FFF);

    // Backpressure: third op must be held until space frees up.
    bus_if.out_ready = 1'b0;
    drive(1'b1, OP_PASS, 16'h0000, 16'h1111);
    tick();
    chk("bp1.in_ready", {31'd0, bus_if.in_ready}, 32'd1);
    chk("bp1.result", {16'd0, bus_if.result}, 32'h1111);
    drive(1'b1, OP_PASS, 16'h0000, 16'h2222);
    tick();
    chk("bp2.in_ready", {31'd0, bus_if.in_ready}, 32'd0);
    chk("bp2.result", {16'd0, bus_if.result}, 32'h1111);
    drive(1'b1, OP_PASS, 16'h0000, 16'h3333);
    tick();
    chk("bp3.in_ready", {31'd0, bus_if.in_ready}, 32'd0);
    chk("bp3.result", {16'd0, bus_if.result}, 32'h1111);
    bus_if.out_ready = 1'b1;
    tick();
    chk("bp_pop1.result", {16'd0, bus_if.result}, 32'h2222);
    chk("bp_pop1.in_ready", {31'd0, bus_if.in_ready}, 32'd1);
    tick();
    drive(1'b0, OP_AND, 16'h0000, 16'h0000);
    chk("bp_pop2.result", {16'd0, bus_if.result}, 32'h3333);
    chk("bp_pop2.valid", {31'd0, bus_if.out_valid}, 32'd1);
    tick();
    chk("bp_done.valid", {31'd0, bus_if.out_valid}, 32'd0);

    // Streaming INC with concurrent push/pop.
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, OP_INC, 16'(i), 16'h0000);
      tick();
      chk($sformatf("stream%0d.result", i), {16'd0, bus_if.result}, 32'(i + 1));
      chk($sformatf("stream%0d.in_ready", i), {31'd0, bus_if.in_ready}, 32'd1);
    end
    drive(1'b0, OP_AND, 16'h0000, 16'h0000);
    tick();
    chk("stream_end.valid", {31'd0, bus_if.out_valid}, 32'd0);

    // Head stays stable under backpressure while inputs toggle unqualified.
    bus_if.out_ready = 1'b0;
    drive(1'b1, OP_PASS, 16'h0000, 16'hABCD);
    tick();
    for (int i = 0; i < 5; i++) begin
      drive(1'b0, 3'($urandom_range(0, 7)), 16'($urandom), 16'($urandom));
      tick();
      chk($sformatf("stable%0d.result", i), {16'd0, bus_if.result}, 32'hABCD);
      chk($sformatf("stable%0d.flags", i), {28'd0, bus_if.flags}, 32'h4);
      chk($sformatf("stable%0d.valid", i), {31'd0, bus_if.out_valid}, 32'd1);
    end

    // Fill to two entries, then reset asynchronously mid-cycle.
    drive(1'b1, OP_PASS, 16'h0000, 16'h5555);
    tick();
    drive(1'b0, OP_AND, 16'h0000, 16'h0000);
    chk("full.in_ready", {31'd0, bus_if.in_ready}, 32'd0);
    #3;
    rst_n = 1'b0;
    #1;
    chk("arst.out_valid", {31'd0, bus_if.out_valid}, 32'd0);
    chk("arst.in_ready", {31'd0, bus_if.in_ready}, 32'd1);
    chk("arst.result", {16'd0, bus_if.result}, 32'h0);
    chk("arst.flags", {28'd0, bus_if.flags}, 32'h0);
    tick();
    rst_n = 1'b1;
    bus_if.out_ready = 1'b1;
    tick();
    chk("post_rst.valid", {31'd0, bus_if.out_valid}, 32'd0);
    one_op("post_rst_add", OP_ADD, 16'h0001, 16'h0002, 16'h0003, 4'b0000);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
